// File: rtl/fifo_pkg.sv
// Shared sizing and types for the asymmetric FIFO controller (16-bit write, 8-bit read).
package fifo_pkg;
    localparam int ADDR_WIDTH = 3;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int CNT_WIDTH  = ADDR_WIDTH + 1;

    typedef logic [ADDR_WIDTH-1:0] ptr_t;
    typedef logic [CNT_WIDTH-1:0]  cnt_t;

    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction
endpackage

// File: rtl/fifo_asym_ctrl_if.sv
// Handshake and register-file control bundle between the FIFO users and the controller.
interface fifo_asym_ctrl_if #(
    parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
);
    logic                  wr;
    logic                  rd;
    logic                  w_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  ovf;
    logic                  udf;

    modport master (
        output wr, rd,
        input  w_en, w_addr, r_addr, full, empty, count, ovf, udf
    );

    modport slave (
        input  wr, rd,
        output w_en, w_addr, r_addr, full, empty, count, ovf, udf
    );
endinterface

// File: rtl/fifo_ptr_cnt.sv
// Wrapping byte-address pointer; advances by i_step when enabled, wraps modulo 2**ADDR_WIDTH.
module fifo_ptr_cnt #(
    parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_en,
    input  logic [ADDR_WIDTH-1:0] i_step,
    output logic [ADDR_WIDTH-1:0] o_ptr
);
    logic [ADDR_WIDTH-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= r_ptr + i_step;
        end
    end

    assign o_ptr = r_ptr;
endmodule

// File: rtl/fifo_asym_ctrl.sv
// Pointer/status controller: two-byte pushes, one-byte pops, count/full/empty and error pulses.
module fifo_asym_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    fifo_asym_ctrl_if.slave        bus
);
    localparam int unsigned DEPTH_L = depth_of(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] FULL_THR = (ADDR_WIDTH+1)'(DEPTH_L - 2);

    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_ovf;
    logic                  r_udf;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic [ADDR_WIDTH:0]   w_count_next;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [ADDR_WIDTH-1:0] w_raddr;

    // Status comes from the registered count only; a same-cycle read never frees room for a write.
    assign w_full  = (r_count > FULL_THR);
    assign w_empty = (r_count == '0);
    assign w_wr_ok = bus.wr & ~w_full;
    assign w_rd_ok = bus.rd & ~w_empty;

    always_comb begin
        w_count_next = r_count;
        w_count_next = w_count_next + {{(ADDR_WIDTH-1){1'b0}}, w_wr_ok, 1'b0};
        w_count_next = w_count_next - {{ADDR_WIDTH{1'b0}}, w_rd_ok};
    end

    fifo_ptr_cnt #(.ADDR_WIDTH(ADDR_WIDTH)) u_wptr (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (w_wr_ok),
        .i_step  (ADDR_WIDTH'(2)),
        .o_ptr   (w_waddr)
    );

    fifo_ptr_cnt #(.ADDR_WIDTH(ADDR_WIDTH)) u_rptr (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (w_rd_ok),
        .i_step  (ADDR_WIDTH'(1)),
        .o_ptr   (w_raddr)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_ovf   <= bus.wr & w_full;
            r_udf   <= bus.rd & w_empty;
        end
    end

    assign bus.w_en   = w_wr_ok;
    assign bus.w_addr = w_waddr;
    assign bus.r_addr = w_raddr;
    assign bus.full   = w_full;
    assign bus.empty  = w_empty;
    assign bus.count  = r_count;
    assign bus.ovf    = r_ovf;
    assign bus.udf    = r_udf;
endmodule
